// File: rtl/core_pkg.sv
// Shared constants of the 4-bit core, used by blocks that snoop its register writes.
package core_pkg;
   localparam int DATA_W = 4;
   localparam logic [1:0] D_RO = 2'b10;

   // Same decode the core uses to enable the RO register.
   function automatic logic is_ro_write(input logic [1:0] dest, input logic en);
      return en && (dest == D_RO);
   endfunction
endpackage

// File: rtl/sync_fifo_ctrl.sv
// FIFO bookkeeping: pointers, occupancy, full/valid flags and push/pop qualification.
module sync_fifo_ctrl #(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_req,
   input  logic          out_ready,
   output logic          wr_en,
   output logic          drop,
   output logic [AW-1:0] wr_ptr,
   output logic [AW-1:0] rd_ptr,
   output logic [AW-1:0] rd_nxt,
   output logic          vld_nxt,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          valid
);
   logic          pop;
   logic [CW-1:0] count_nxt;

   // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
   always_comb begin
      pop       = valid && out_ready;
      wr_en     = push_req && (!full || pop);
      drop      = push_req && full && !pop;
      rd_nxt    = rd_ptr + AW'(pop);
      count_nxt = count + CW'(wr_en) - CW'(pop);
      vld_nxt   = (count_nxt != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         valid  <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + AW'(wr_en);
         rd_ptr <= rd_nxt;
         count  <= count_nxt;
         full   <= (count_nxt == CW'(DEPTH));
         valid  <= vld_nxt;
      end
   end
endmodule

// File: rtl/out_capture_fifo.sv
// Captures every value the core writes to RO and drains it over valid/ready,
// flagging (never stalling) when output is lost.
module out_capture_fifo
   import core_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = DATA_W,
   parameter bit DEDUP = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   o_wen,
   input  logic [DW-1:0]          o_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DW-1:0]          out_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   overflow,
   input  logic                   clr_ovf
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] last_data;
   logic          last_valid;
   logic          push_req, wr_en, drop, vld_nxt;
   logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;

   assign push_req = o_wen && !(DEDUP && last_valid && (o_data == last_data));

   sync_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
      .clk       (clk),
      .reset     (reset),
      .push_req  (push_req),
      .out_ready (out_ready),
      .wr_en     (wr_en),
      .drop      (drop),
      .wr_ptr    (wr_ptr),
      .rd_ptr    (rd_ptr),
      .rd_nxt    (rd_nxt),
      .vld_nxt   (vld_nxt),
      .count     (count),
      .full      (full),
      .valid     (out_valid)
   );

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= o_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_data   <= '0;
         overflow   <= 1'b0;
         last_data  <= '0;
         last_valid <= 1'b0;
      end else begin
         // Register the next head; bypass when it is the slot written this cycle.
         // With no next head, keep the last popped value.
         if (vld_nxt)
            out_data <= (wr_en && (wr_ptr == rd_nxt)) ? o_data : mem[rd_nxt];
         if (drop)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
         // Track what the core emitted, even if the FIFO dropped it.
         if (push_req) begin
            last_data  <= o_data;
            last_valid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_out_capture_fifo.sv
// Scoreboard bench: stimulus queues expected outputs, negedge monitors check every handshake.
module tb_out_capture_fifo;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clr_ovf = 1'b0;
   logic       o_wen = 1'b0, o_wen_d = 1'b0;
   logic [3:0] o_data = '0, o_data_d = '0;
   logic       out_ready = 1'b0, out_ready_d = 1'b0;
   logic       out_valid, out_valid_d, full, full_d, overflow, overflow_d;
   logic [3:0] out_data, out_data_d;
   logic [2:0] count, count_d;

   int n_chk = 0;
   int n_fail = 0;
   logic [3:0] exp_q[$];
   logic [3:0] exp_qd[$];

   always #5 clk = ~clk;

   out_capture_fifo #(.DEPTH(4), .DW(4), .DEDUP(1'b0)) dut (
      .clk(clk), .reset(reset), .o_wen(o_wen), .o_data(o_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .full(full), .overflow(overflow), .clr_ovf(clr_ovf));

   out_capture_fifo #(.DEPTH(4), .DW(4), .DEDUP(1'b1)) dut_d (
      .clk(clk), .reset(reset), .o_wen(o_wen_d), .o_data(o_data_d),
      .out_valid(out_valid_d), .out_ready(out_ready_d), .out_data(out_data_d),
      .count(count_d), .full(full_d), .overflow(overflow_d), .clr_ovf(clr_ovf));

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitors: a handshake completes at the next rising edge.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) check("unexpected_pop", int'(out_data), -1);
         else check("drain_data", int'(out_data), int'(exp_q.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (!reset && out_valid_d && out_ready_d) begin
         if (exp_qd.size() == 0) check("dedup_unexpected_pop", int'(out_data_d), -1);
         else check("dedup_drain_data", int'(out_data_d), int'(exp_qd.pop_front()));
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One cycle with a push; stored=1 means the value must come out later.
   task automatic push(input logic [3:0] v, input bit stored);
      o_wen  = 1'b1;
      o_data = v;
      if (stored) exp_q.push_back(v);
      cyc();
      o_wen = 1'b0;
   endtask

   task automatic push_d(input logic [3:0] v, input bit stored);
      o_wen_d  = 1'b1;
      o_data_d = v;
      if (stored) exp_qd.push_back(v);
      cyc();
      o_wen_d = 1'b0;
   endtask

   initial begin
      // Reset then idle
      cyc(2);
      reset = 1'b0;
      check("rst_valid", out_valid, 0);
      check("rst_count", count, 0);
      check("rst_overflow", overflow, 0);
      check("rst_full", full, 0);
      check("rst_data", out_data, 0);
      cyc(10);
      check("idle_valid", out_valid, 0);
      check("idle_count", count, 0);

      // Hold under back-pressure, then drain
      push(4'd3, 1);
      push(4'd5, 1);
      push(4'd9, 1);
      check("three_count", count, 3);
      check("three_head", out_data, 3);
      cyc(2);
      check("hold_head", out_data, 3);
      check("hold_valid", out_valid, 1);
      out_ready = 1'b1;
      cyc(3);
      out_ready = 1'b0;
      check("drained_valid", out_valid, 0);
      check("drained_count", count, 0);
      check("empty_holds_last", out_data, 9);

      // Fill, overflow (set beats clear), clear
      push(4'd1, 1);
      push(4'd2, 1);
      push(4'd3, 1);
      check("not_full_3", full, 0);
      push(4'd4, 1);
      check("full_4", full, 1);
      check("count_4", count, 4);
      clr_ovf = 1'b1;
      push(4'd7, 0);
      clr_ovf = 1'b0;
      check("ovf_set_wins", overflow, 1);
      check("ovf_count", count, 4);
      clr_ovf = 1'b1;
      cyc();
      clr_ovf = 1'b0;
      check("ovf_cleared", overflow, 0);

      // Push and pop while full
      out_ready = 1'b1;
      push(4'd6, 1);
      out_ready = 1'b0;
      check("fullpp_count", count, 4);
      check("fullpp_ovf", overflow, 0);
      check("fullpp_full", full, 1);
      out_ready = 1'b1;
      cyc(4);
      out_ready = 1'b0;
      check("fullpp_empty", count, 0);

      // Streaming push/pop across pointer wrap
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) push(4'(i % 16), 1);
      cyc();
      out_ready = 1'b0;
      check("wrap_count", count, 0);
      check("wrap_valid", out_valid, 0);

      // Reset mid-drain discards contents
      push(4'd1, 1);
      push(4'd2, 1);
      check("pre_rst_count", count, 2);
      out_ready = 1'b1;
      reset = 1'b1;
      exp_q.delete();
      cyc();
      reset = 1'b0;
      check("midrst_count", count, 0);
      check("midrst_valid", out_valid, 0);
      check("midrst_data", out_data, 0);
      push(4'd10, 1);
      cyc(2);
      out_ready = 1'b0;
      check("post_rst_count", count, 0);

      // Duplicate suppression
      push_d(4'd2, 1);
      push_d(4'd2, 0);
      push_d(4'd3, 1);
      push_d(4'd3, 0);
      push_d(4'd2, 1);
      check("dedup_count", count_d, 3);
      out_ready_d = 1'b1;
      cyc(3);
      out_ready_d = 1'b0;
      check("dedup_empty", count_d, 0);

      check("sb_left", exp_q.size(), 0);
      check("sb_d_left", exp_qd.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end
endmodule
